ram_responder: RTL

Memory-side responder for the data cache's fill and writeback traffic. The cache acts as the initiator: it presents one word request at a time and holds it until it sees `ACCESS`. This block answers that request, models memory latency with a wait counter, stores data in an internal word array, and reports progress on the shared `ramstate_t` status (`FREE`/`BUSY`/`ACCESS`/`ERROR`). It sits below the dcache in place of the bus/arbiter and is the target used by cache benches.

---
 rtl/cpu_types_package.sv | 37 +++
 rtl/ram_responder_array.sv | 26 ++
 rtl/ram_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_types_package.sv
// Shared CPU/memory types used between the dcache and its memory-side responder.
// Holds the RAM status encoding, the dcache address split, and the responder's defaults.
package cpu_types_package;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int WORDS  = 2;
    localparam int DTAG_W = 26;
    localparam int DIDX_W = 3;
    localparam int DBLK_W = 1;
    localparam int DBYT_W = 2;

    typedef struct packed {
        logic [DTAG_W-1:0] tag;
        logic [DIDX_W-1:0] idx;
        logic [DBLK_W-1:0] blkoff;
        logic [DBYT_W-1:0] bytoff;
    } dcachef_t;

    localparam int RAM_LAT     = 2;
    localparam int RAM_DEPTH_W = 10;

    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
    } ramreq_t;

endpackage

// File: rtl/ram_responder_array.sv
// Word storage for ram_responder: synchronous write, combinational read, single port.
// Latency: read data follows addr combinationally; a write lands on the next rising edge.
// Backpressure: none; the owner sequences every access.
module ram_array
    import cpu_types_package::*;
#(
    parameter int DEPTH_W = RAM_DEPTH_W
) (
    input  logic               core_clk,
    input  logic               wr_vld,
    input  logic [DEPTH_W-1:0] addr,
    input  word_t              wr_dat,
    output word_t              rd_dat
);

    word_t mem [0:(1<<DEPTH_W)-1];

    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            mem[addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[addr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for dcache word requests; optional burst shortcut under RAM_BURST_EN.
// Latency: LAT BUSY cycles then one ACCESS cycle per word (one cycle when a burst hit skips BUSY).
// Backpressure: the requester holds its request until ACCESS; a changed request in BUSY aborts it.
module ram_responder
    import cpu_types_package::*;
#(
    parameter int LAT     = RAM_LAT,
    parameter int DEPTH_W = RAM_DEPTH_W
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int CNT_W = 4;

    ramstate_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ramreq_t          req_q, req_d;
    ramreq_t          live_req;
    logic             bad_req;
    logic             mem_we;
    word_t            rd_dat;

    assign live_req = '{ren: ramREN, wen: ramWEN, addr: ramaddr};
    assign bad_req  = (ramREN && ramWEN) || (ramaddr[1:0] != 2'b00)
                    || ((ramaddr >> (DEPTH_W + 2)) != '0);

`ifdef RAM_BURST_EN
    logic    burst_vld_q, burst_vld_d;
    ramreq_t last_q, last_d;

    // Next word of the same dcache block with the same op as the word just served.
    function automatic logic is_burst(input ramreq_t last, input ramreq_t nxt);
        dcachef_t l;
        dcachef_t n;
        l = dcachef_t'(last.addr);
        n = dcachef_t'(nxt.addr);
        return (nxt.ren == last.ren) && (nxt.wen == last.wen)
            && (n.tag == l.tag) && (n.idx == l.idx) && (n.bytoff == '0)
            && (l.blkoff != DBLK_W'(WORDS - 1))
            && (n.blkoff == l.blkoff + DBLK_W'(1));
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        mem_we  = 1'b0;
`ifdef RAM_BURST_EN
        burst_vld_d = burst_vld_q;
        last_d      = last_q;
`endif
        unique case (state_q)
            FREE: begin
`ifdef RAM_BURST_EN
                burst_vld_d = 1'b0;
`endif
                if (ramREN || ramWEN) begin
                    if (bad_req) begin
                        state_d = ERROR;
                    end else begin
                        req_d = live_req;
`ifdef RAM_BURST_EN
                        if (burst_vld_q && is_burst(last_q, live_req)) begin
                            state_d = ACCESS;
                        end else begin
                            state_d = BUSY;
                            cnt_d   = CNT_W'(LAT - 1);
                        end
`else
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LAT - 1);
`endif
                    end
                end
            end
            BUSY: begin
                if (live_req != req_q) begin
                    state_d = FREE;
                end else if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACCESS: begin
                state_d = FREE;
                mem_we  = req_q.wen;
`ifdef RAM_BURST_EN
                burst_vld_d = 1'b1;
                last_d      = req_q;
`endif
            end
            ERROR: begin
                state_d = FREE;
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FREE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

`ifdef RAM_BURST_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            burst_vld_q <= 1'b0;
            last_q      <= '0;
        end else begin
            burst_vld_q <= burst_vld_d;
            last_q      <= last_d;
        end
    end
`endif

    // Reset on the closing edge of ACCESS must drop the pending write.
    ram_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .core_clk (CLK),
        .wr_vld   (mem_we && nRST),
        .addr     (req_q.addr[DEPTH_W+1:2]),
        .wr_dat   (ramstore),
        .rd_dat   (rd_dat)
    );

    assign ramstate = state_q;
    assign ramload  = (state_q == ACCESS && req_q.ren) ? rd_dat : '0;

endmodule
